// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } tt_state_e;

  // Width of the settle down-counter; covers SETTLE_CYCLES up to 255.
  localparam int unsigned CntW = 8;

  function automatic int unsigned sig_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; terminal_o flags the last settle cycle (count == 1).
module tt_settle_timer
  import tt_sweep_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic [CntW-1:0] value_o,
  output logic            terminal_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o    = cnt_q;
  assign terminal_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every CUT input combination, captures the truth-table signature and compares it.
// Optional macro TT_STABILITY_CHECK_EN adds the unstable output (settle vs sample disagreement).
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [sig_width(N_IN)-1:0]  expected,
  output logic [N_IN-1:0]             dut_in,
  input  logic                        dut_out,
  output logic                        busy,
  output logic                        done,
  output logic [sig_width(N_IN)-1:0]  signature,
  output logic                        match
`ifdef TT_STABILITY_CHECK_EN
  ,
  output logic                        unstable
`endif
);

  localparam int unsigned SigW = sig_width(N_IN);
  localparam logic [N_IN-1:0] LastIdx = {N_IN{1'b1}};

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [SigW-1:0] sig_q, sig_d;
  logic [SigW-1:0] exp_q, exp_d;
  logic            match_q, match_d;
  logic            tmr_load, tmr_dec, tmr_term;
  logic [CntW-1:0] tmr_value;

`ifdef TT_STABILITY_CHECK_EN
  logic settle_smp_q, settle_smp_d;
  logic unstable_q, unstable_d;
`endif

  tt_settle_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (CntW'(SETTLE_CYCLES)),
    .dec_i      (tmr_dec),
    .value_o    (tmr_value),
    .terminal_o (tmr_term)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sig_d    = sig_q;
    exp_d    = exp_q;
    match_d  = match_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`ifdef TT_STABILITY_CHECK_EN
    settle_smp_d = settle_smp_q;
    unstable_d   = unstable_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sig_d    = '0;
          exp_d    = expected;
          idx_d    = '0;
          match_d  = 1'b0;
          tmr_load = 1'b1;
          state_d  = StSettle;
`ifdef TT_STABILITY_CHECK_EN
          unstable_d = 1'b0;
`endif
        end
      end
      StSettle: begin
        tmr_dec = 1'b1;
        if (tmr_term) begin
          state_d = StSample;
`ifdef TT_STABILITY_CHECK_EN
          settle_smp_d = dut_out;
`endif
        end
      end
      StSample: begin
        sig_d[idx_q] = dut_out;
`ifdef TT_STABILITY_CHECK_EN
        if (dut_out != settle_smp_q) begin
          unstable_d = 1'b1;
        end
`endif
        if (idx_q == LastIdx) begin
          state_d = StDone;
`ifdef TT_STABILITY_CHECK_EN
          match_d = (sig_d == exp_q) && !unstable_d;
`else
          match_d = (sig_d == exp_q);
`endif
        end else begin
          idx_d    = idx_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sig_q   <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
`ifdef TT_STABILITY_CHECK_EN
      settle_smp_q <= 1'b0;
      unstable_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      match_q <= match_d;
`ifdef TT_STABILITY_CHECK_EN
      settle_smp_q <= settle_smp_d;
      unstable_q   <= unstable_d;
`endif
    end
  end

  assign busy      = (state_q == StSettle) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign dut_in    = busy ? idx_q : '0;
  assign signature = sig_q;
  assign match     = match_q;

`ifdef TT_STABILITY_CHECK_EN
  // The flag is only presented once the sweep has finished.
  assign unstable = unstable_q && !busy;
`endif

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream and downstream of a combinational N-input gate-level logic circuit under test (CUT), such as a 3-input NOR/NOT netlist.
- Drives every input combination into the CUT in ascending index order and waits a programmable settle time per vector.
- Samples the single CUT output for each vector and assembles the truth-table signature, e.g. 0x18.
- Compares the signature against an expected value for circuit-score and regression flows.

Parameters:
- N_IN, 3, number of CUT inputs; valid range 1..6; signature width is 2**N_IN.
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; valid range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- expected  input  2**N_IN  reference truth table; captured on accepted start
- dut_in  output  N_IN  CUT input vector; bit N_IN-1 is the MSB of the truth-table index
- dut_out  input  1  CUT output
- busy  output  1  high from the cycle after start acceptance until DONE
- done  output  1  one-cycle pulse when the sweep completes
- signature  output  2**N_IN  captured truth table; bit k = dut_out for index k
- match  output  1  signature == captured expected; valid while done=1 and held until the next accepted start

Behaviour:
- Reset values: dut_in=0, busy=0, done=0, signature=0, match=0, state=IDLE, idx=0, settle count=0.
- States and transitions:
  - IDLE: start=1 clears signature, captures expected, sets idx=0, loads settle count=SETTLE_CYCLES, then goes to SETTLE.
  - SETTLE: decrements the count each cycle; on reaching 1, goes to SAMPLE.
  - SAMPLE: writes signature[idx] <= dut_out.
    - If idx == 2**N_IN-1, goes to DONE.
    - Otherwise idx++, reloads the count, and goes to SETTLE.
  - DONE: done=1 and match valid for one cycle; busy=0; then goes to IDLE.
- Vector timing: dut_in = idx while in SETTLE/SAMPLE and 0 otherwise. Each vector is held exactly SETTLE_CYCLES+1 cycles.
- Latency: with start accepted at cycle t, done=1 at cycle t + 2**N_IN*(SETTLE_CYCLES+1) + 1.
- Start while busy: ignored, with no effect on idx, signature or expected.
- Start in the DONE cycle: ignored.
- Changes to expected: ignored after capture.
- Index wrap: idx never wraps within a sweep; the terminal compare is on 2**N_IN-1.
- match: registered on the SAMPLE→DONE transition and held in IDLE.
- Reset mid-sweep: aborts on the next edge; every output returns to its reset value and no done pulse is issued.

Optional Feature:
- Macro: TT_STABILITY_CHECK_EN.
- With the macro defined:
  - Adds output port unstable (1 bit).
  - dut_out is also sampled on the final SETTLE cycle of each vector. If that sample differs from the SAMPLE-cycle value, a sticky flag is set.
  - unstable presents the flag together with done and holds it until the next accepted start.
  - match is forced to 0 when the flag is set.
- Without the macro: the port is absent and match is the pure signature compare.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum: IDLE, SETTLE, SAMPLE, DONE;
  - localparam function for signature width (2**N_IN);
  - settle count width constant (8 bits).
- One sub-module, tt_settle_timer: loadable down-counter with load, value and a terminal flag (count==1). The top FSM instantiates it once.

Test Plan:
- 0x18 netlist connected as in1=dut_in[2], in2=dut_in[1], in3=dut_in[0]; expected=0x18; start -> done at cycle t+41 (defaults), signature=0x18, match=1.
- dut_out tied 0; expected=0x18 -> signature=0x00, match=0; then expected=0x00 on a new sweep -> match=1.
- CUT = dut_in[0] XOR dut_in[1] XOR dut_in[2] (parity), SETTLE_CYCLES=1 -> done at t+17, signature=0x96.
- start pulsed again at t+10 and expected changed mid-sweep -> no restart, same done cycle, match uses the originally captured expected.
- rst asserted at t+20 -> next cycle busy=0, dut_in=0, signature=0; done never pulses; a fresh start then completes normally.
- TT_STABILITY_CHECK_EN: CUT output toggles between the last SETTLE and SAMPLE cycles for idx=5 -> unstable=1 and match=0 at done.
